// File: rtl/axil_slave_monitor_pkg.sv
// Shared error-code definitions and helpers for the AXI4-lite slave monitor.
package axil_slave_monitor_pkg;

  localparam int unsigned ERR_AW_STAB   = 0;
  localparam int unsigned ERR_W_STAB    = 1;
  localparam int unsigned ERR_AR_STAB   = 2;
  localparam int unsigned ERR_RESP_STAB = 3;
  localparam int unsigned ERR_B_ORPHAN  = 4;
  localparam int unsigned ERR_R_ORPHAN  = 5;
  localparam int unsigned ERR_TIMEOUT   = 6;
  localparam int unsigned ERR_OVF       = 7;
  localparam int unsigned ERR_RSVD      = 8;

  localparam int unsigned ERR_W      = 9;
  localparam int unsigned ERR_CODE_W = 4;

  localparam logic [ERR_CODE_W-1:0] ERR_NONE = 4'hF;

  // Index of the lowest set violation bit, ERR_NONE when none is set.
  function automatic logic [ERR_CODE_W-1:0] first_err(input logic [ERR_W-1:0] v);
    logic [ERR_CODE_W-1:0] code;
    code = ERR_NONE;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (v[i]) code = ERR_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/axil_mon_chan.sv
// Per-channel handshake stability checker: once valid is seen without ready,
// the next cycle must keep valid high and the payload unchanged.
module axil_mon_chan #(
  parameter int unsigned PAYLOAD_W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic                 ready,
  input  logic [PAYLOAD_W-1:0] payload,
  output logic                 err
);

  logic                 stall_d, stall_q;
  logic [PAYLOAD_W-1:0] payload_d, payload_q;

  // Next-state: remember whether this cycle stalled and what was offered.
  always_comb begin
    stall_d   = valid & ~ready;
    payload_d = payload;
  end

  // Stall and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      stall_q   <= stall_d;
      payload_q <= payload_d;
    end
  end

  // A stalled transfer may not be withdrawn or altered.
  always_comb begin
    err = stall_q & (~valid | (payload != payload_q));
  end

endmodule

// File: rtl/axil_slave_monitor.sv
// Passive AXI4-lite slave-port monitor: outstanding counters, response
// legality, handshake stability, response timeouts and sticky error capture.
module axil_slave_monitor
  import axil_slave_monitor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned OUTSTAND_MAX   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CW            = $clog2(OUTSTAND_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  input  logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  input  logic                  s_axil_wready,
  input  logic [1:0]            s_axil_bresp,
  input  logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  input  logic                  s_axil_arready,
  input  logic [DATA_WIDTH-1:0] s_axil_rdata,
  input  logic [1:0]            s_axil_rresp,
  input  logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  input  logic                  clear,
  output logic [CW-1:0]         aw_outstanding,
  output logic [CW-1:0]         w_outstanding,
  output logic [CW-1:0]         ar_outstanding,
  output logic [ERR_W-1:0]      err_flags,
  output logic                  err_any,
  output logic [ERR_CODE_W-1:0] err_first
);

  localparam logic [CW-1:0] CntMax = CW'(OUTSTAND_MAX);
  localparam int unsigned   TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMax   = TW'(TIMEOUT_CYCLES);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_stab_err, w_stab_err, b_stab_err, ar_stab_err, r_stab_err;

  logic [CW-1:0]         aw_cnt_d, aw_cnt_q, w_cnt_d, w_cnt_q, ar_cnt_d, ar_cnt_q;
  logic [TW-1:0]         wr_timer_d, wr_timer_q, rd_timer_d, rd_timer_q;
  logic                  wr_active, rd_active, ovf, timeout;
  logic [ERR_W-1:0]      viol;
  logic [ERR_W-1:0]      err_flags_d, err_flags_q;
  logic [ERR_CODE_W-1:0] err_first_d, err_first_q;

  // Saturating up/down step; simultaneous inc and dec cancel.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic inc,
                                             input logic dec);
    logic [CW-1:0] n;
    n = c;
    if (inc && !dec && c != CntMax) n = c + 1'b1;
    if (dec && !inc && c != '0)     n = c - 1'b1;
    return n;
  endfunction

  // Handshake decode.
  always_comb begin
    aw_hs = s_axil_awvalid & s_axil_awready;
    w_hs  = s_axil_wvalid  & s_axil_wready;
    b_hs  = s_axil_bvalid  & s_axil_bready;
    ar_hs = s_axil_arvalid & s_axil_arready;
    r_hs  = s_axil_rvalid  & s_axil_rready;
  end

  axil_mon_chan #(.PAYLOAD_W(ADDR_WIDTH + 3)) u_chan_aw (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (s_axil_awvalid),
    .ready   (s_axil_awready),
    .payload ({s_axil_awprot, s_axil_awaddr}),
    .err     (aw_stab_err)
  );

  axil_mon_chan #(.PAYLOAD_W(DATA_WIDTH + STRB_WIDTH)) u_chan_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (s_axil_wvalid),
    .ready   (s_axil_wready),
    .payload ({s_axil_wstrb, s_axil_wdata}),
    .err     (w_stab_err)
  );

  axil_mon_chan #(.PAYLOAD_W(2)) u_chan_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (s_axil_bvalid),
    .ready   (s_axil_bready),
    .payload (s_axil_bresp),
    .err     (b_stab_err)
  );

  axil_mon_chan #(.PAYLOAD_W(ADDR_WIDTH + 3)) u_chan_ar (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (s_axil_arvalid),
    .ready   (s_axil_arready),
    .payload ({s_axil_arprot, s_axil_araddr}),
    .err     (ar_stab_err)
  );

  axil_mon_chan #(.PAYLOAD_W(DATA_WIDTH + 2)) u_chan_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (s_axil_rvalid),
    .ready   (s_axil_rready),
    .payload ({s_axil_rresp, s_axil_rdata}),
    .err     (r_stab_err)
  );

  // Outstanding counters and overflow detection.
  always_comb begin
    aw_cnt_d = cnt_next(aw_cnt_q, aw_hs, b_hs);
    w_cnt_d  = cnt_next(w_cnt_q,  w_hs,  b_hs);
    ar_cnt_d = cnt_next(ar_cnt_q, ar_hs, r_hs);
    ovf      = (aw_hs & ~b_hs & (aw_cnt_q == CntMax)) |
               (w_hs  & ~b_hs & (w_cnt_q  == CntMax)) |
               (ar_hs & ~r_hs & (ar_cnt_q == CntMax));
  end

  // Response timers; they restart on every response and idle when nothing is owed.
  always_comb begin
    wr_active  = (aw_cnt_q != '0) && (w_cnt_q != '0);
    rd_active  = (ar_cnt_q != '0);
    wr_timer_d = wr_timer_q;
    rd_timer_d = rd_timer_q;
    if (!wr_active || b_hs)     wr_timer_d = '0;
    else if (wr_timer_q != TMax) wr_timer_d = wr_timer_q + 1'b1;
    if (!rd_active || r_hs)     rd_timer_d = '0;
    else if (rd_timer_q != TMax) rd_timer_d = rd_timer_q + 1'b1;
    // Flag in the cycle the timer reaches the limit so the bit shows exactly
    // TIMEOUT_CYCLES cycles after counting started.
    timeout = (TIMEOUT_CYCLES != 0) &&
              ((wr_active && !b_hs && wr_timer_d == TMax) ||
               (rd_active && !r_hs && rd_timer_d == TMax));
  end

  // Collect this cycle's violations; legality uses registered counts only.
  always_comb begin
    viol                = '0;
    viol[ERR_AW_STAB]   = aw_stab_err;
    viol[ERR_W_STAB]    = w_stab_err;
    viol[ERR_AR_STAB]   = ar_stab_err;
    viol[ERR_RESP_STAB] = b_stab_err | r_stab_err;
    viol[ERR_B_ORPHAN]  = s_axil_bvalid & ((aw_cnt_q == '0) | (w_cnt_q == '0));
    viol[ERR_R_ORPHAN]  = s_axil_rvalid & (ar_cnt_q == '0);
    viol[ERR_TIMEOUT]   = timeout;
    viol[ERR_OVF]       = ovf;
    viol[ERR_RSVD]      = 1'b0;
  end

  // Sticky capture; clear wins over any same-cycle violation.
  always_comb begin
    err_flags_d = err_flags_q;
    err_first_d = err_first_q;
    if (clear) begin
      err_flags_d = '0;
      err_first_d = ERR_NONE;
    end else begin
      err_flags_d = err_flags_q | viol;
      if (!err_any && viol != '0) err_first_d = first_err(viol);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt_q    <= '0;
      w_cnt_q     <= '0;
      ar_cnt_q    <= '0;
      wr_timer_q  <= '0;
      rd_timer_q  <= '0;
      err_flags_q <= '0;
      err_first_q <= ERR_NONE;
    end else begin
      aw_cnt_q    <= aw_cnt_d;
      w_cnt_q     <= w_cnt_d;
      ar_cnt_q    <= ar_cnt_d;
      wr_timer_q  <= wr_timer_d;
      rd_timer_q  <= rd_timer_d;
      err_flags_q <= err_flags_d;
      err_first_q <= err_first_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    aw_outstanding = aw_cnt_q;
    w_outstanding  = w_cnt_q;
    ar_outstanding = ar_cnt_q;
    err_flags      = err_flags_q;
    err_any        = |err_flags_q;
    err_first      = err_first_q;
  end

endmodule
